// File: rtl/demux_pkg.sv
// Shared defaults and the per-channel state type for the registered bus demultiplexer.
package demux_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One destination channel: data register plus a sticky valid flag cleared by ack.
// Optional build macro DEMUX_ZERO_IDLE_EN: the data output reads zero while the channel is empty.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    chan_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: a write always lands (the top only loads when the channel can take it),
    // an ack without a write empties the channel, an ack on an empty channel is ignored.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            EMPTY: begin
                if (load_i) begin
                    state_d = FULL;
                    data_d  = data_i;
                end
            end
            FULL: begin
                if (load_i) begin
                    state_d = FULL;
                    data_d  = data_i;
                end else if (ack_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers; reset discards any pending word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == FULL);

`ifdef DEMUX_ZERO_IDLE_EN
    // Legacy zero-fill view for downstream OR-combining; the register itself keeps its word.
    assign data_o = valid_o ? data_q : '0;
`else
    assign data_o = data_q;
`endif

endmodule

// File: rtl/demux_bus_reg_nch.sv
// Registered, back-pressured demultiplexer from the shared bus to NUM_CH channel registers.
// Out-of-range selects are accepted and dropped, flagged by SEL_ERR and counted in DROP_CNT.
// Optional build macro DEMUX_ZERO_IDLE_EN (handled inside demux_chan_reg).
module demux_bus_reg_nch
    import demux_pkg::*;
#(
    parameter int   DATA_W = DATA_W_DEF,
    parameter int   NUM_CH = NUM_CH_DEF,
    parameter int   CNT_W  = CNT_W_DEF,
    localparam int  SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [DATA_W-1:0]        FROM_BUS,
    input  logic [SEL_W-1:0]         SEL_BUS,
    input  logic                     BUS_VALID,
    output logic                     BUS_READY,
    output logic [NUM_CH*DATA_W-1:0] R_FLAT,
    output logic [NUM_CH-1:0]        R_VALID,
    input  logic [NUM_CH-1:0]        R_ACK,
    output logic                     SEL_ERR,
    output logic [CNT_W-1:0]         DROP_CNT
);

    logic [NUM_CH-1:0] hit;       // one-hot decode of SEL_BUS, all zero when out of range
    logic [NUM_CH-1:0] ch_ready;  // channel can take a word this cycle
    logic [NUM_CH-1:0] load;
    logic              in_range;
    logic              drop;

    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign hit[gi]      = (SEL_BUS == SEL_W'(gi));
            assign ch_ready[gi] = !R_VALID[gi] | R_ACK[gi];
            assign load[gi]     = BUS_VALID & hit[gi] & ch_ready[gi];

            demux_chan_reg #(
                .DATA_W (DATA_W)
            ) u_chan (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .load_i  (load[gi]),
                .ack_i   (R_ACK[gi]),
                .data_i  (FROM_BUS),
                .data_o  (R_FLAT[gi*DATA_W +: DATA_W]),
                .valid_o (R_VALID[gi])
            );
        end
    endgenerate

    // Ready depends only on the selected channel's occupancy and ack, never on BUS_VALID.
    assign in_range  = |hit;
    assign BUS_READY = in_range ? |(hit & ch_ready) : 1'b1;
    assign drop      = BUS_VALID & !in_range;

    // Drop bookkeeping: error pulse follows each dropped word, counter saturates.
    always_comb begin
        sel_err_d  = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Drop status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign SEL_ERR  = sel_err_q;
    assign DROP_CNT = drop_cnt_q;

endmodule
